// File: rtl/buzzer_pkg.sv
// Purpose: shared types and musical constants for the buzzer arbiter slice.
// Latency: n/a (package only).
// Backpressure: n/a. Contents: FSM state encoding, clock rate, tone/duration helpers.
package buzzer_pkg;

    // Arbiter FSM states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_GAP  = 2'd2
    } buzz_state_e;

    localparam int unsigned CLK_HZ = 100_000_000;

    // Half-period in clocks for a square wave of freq_hz; 0 Hz maps to a rest.
    function automatic int unsigned HALF_PERIOD(input int unsigned freq_hz);
        if (freq_hz == 0) begin
            return 0;
        end
        return CLK_HZ / (2 * freq_hz);
    endfunction

    // Note durations in clocks at 120 BPM (quarter note = 0.5 s).
    localparam int unsigned QUARTER = CLK_HZ / 2;
    localparam int unsigned EIGHTH  = QUARTER / 2;
    localparam int unsigned HALF    = QUARTER * 2;
    localparam int unsigned WHOLE   = QUARTER * 4;

    // A few handy pitches.
    localparam int unsigned NOTE_A4 = HALF_PERIOD(440);
    localparam int unsigned NOTE_C5 = HALF_PERIOD(523);
    localparam int unsigned NOTE_E5 = HALF_PERIOD(659);

endpackage

// File: rtl/buzzer_tone_gen.sv
// Purpose: square-wave generator; toggles buzz every half_period clocks while enabled.
// Latency: load clears buzz on the next edge; first toggle half_period clocks after load.
// Backpressure: none. Ports: clk, rst (sync, high), en, load, half_period[HP_W], buzz.
module buzzer_tone_gen
    import buzzer_pkg::*;
#(
    parameter int unsigned HP_W = 20
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            load,
    input  logic [HP_W-1:0] half_period,
    output logic            buzz
);

    logic [HP_W-1:0] hp_q, hp_d;
    logic [HP_W-1:0] tone_cnt_q, tone_cnt_d;
    logic            buzz_q, buzz_d;

    always_comb begin
        hp_d       = hp_q;
        tone_cnt_d = tone_cnt_q;
        buzz_d     = buzz_q;
        if (load) begin
            // New note: latch pitch and restart the wave from the low phase.
            hp_d       = half_period;
            tone_cnt_d = '0;
            buzz_d     = 1'b0;
        end else if (!en || (hp_q == '0)) begin
            // Disabled or a rest: hold the buzzer silent.
            tone_cnt_d = '0;
            buzz_d     = 1'b0;
        end else if (tone_cnt_q == hp_q - HP_W'(1)) begin
            tone_cnt_d = '0;
            buzz_d     = ~buzz_q;
        end else begin
            tone_cnt_d = tone_cnt_q + HP_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hp_q       <= '0;
            tone_cnt_q <= '0;
            buzz_q     <= 1'b0;
        end else begin
            hp_q       <= hp_d;
            tone_cnt_q <= tone_cnt_d;
            buzz_q     <= buzz_d;
        end
    end

    assign buzz = buzz_q;

endmodule

// File: rtl/buzzer_arbiter.sv
// Purpose: fixed-priority sharing of one buzzer among N_REQ tone requesters, with optional preemption and a silent gap.
// Latency: req seen in IDLE at t -> ack t+1, done t+dur+1, next ack no earlier than t+dur+GAP_CYCLES+2.
// Backpressure: req is a level held until ack; owner's req is masked after ack until it drops. Outputs all registered.
module buzzer_arbiter
    import buzzer_pkg::*;
#(
    parameter int unsigned N_REQ      = 3,
    parameter int unsigned HP_W       = 20,
    parameter int unsigned DUR_W      = 28,
    parameter int unsigned GAP_CYCLES = 5_000_000,
    parameter int unsigned PREEMPT    = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*HP_W-1:0]      req_half_period,
    input  logic [N_REQ*DUR_W-1:0]     req_duration,
    output logic [N_REQ-1:0]           ack,
    output logic [N_REQ-1:0]           done,
    output logic [N_REQ-1:0]           abort,
    output logic                       busy,
    output logic [$clog2(N_REQ)-1:0]   owner,
    output logic                       buzz
);

    localparam int unsigned OWN_W      = $clog2(N_REQ);
    // Gap counter runs 0..GAP_CYCLES-1.
    localparam int unsigned GAP_W      = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int unsigned GAP_LAST_I = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_LAST_I[GAP_W-1:0];

    buzz_state_e        state_q, state_d;
    logic [OWN_W-1:0]   owner_q, owner_d;
    logic [DUR_W-1:0]   dur_q, dur_d;
    logic [DUR_W-1:0]   dur_cnt_q, dur_cnt_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic [N_REQ-1:0]   ack_q, ack_d;
    logic [N_REQ-1:0]   done_q, done_d;
    logic [N_REQ-1:0]   abort_q, abort_d;
    logic               busy_q, busy_d;
    // A requester that has been acked stays masked until it drops its req.
    logic [N_REQ-1:0]   stale_q, stale_d;

    logic [N_REQ-1:0]   req_eff;
    logic               sel_vld;
    logic [OWN_W-1:0]   sel_idx;
    logic [HP_W-1:0]    sel_hp;
    logic [DUR_W-1:0]   sel_dur;
    logic [DUR_W-1:0]   sel_dur_eff;
    logic               pre_vld;
    logic               grant;
    logic               tone_load;
    logic               tone_en;

    assign req_eff = req & ~stale_q;

    // Priority encoder: scan from the top so the lowest index wins.
    always_comb begin
        sel_vld = 1'b0;
        sel_idx = '0;
        sel_hp  = '0;
        sel_dur = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_eff[i]) begin
                sel_vld = 1'b1;
                sel_idx = OWN_W'(i);
                sel_hp  = req_half_period[i*HP_W +: HP_W];
                sel_dur = req_duration[i*DUR_W +: DUR_W];
            end
        end
    end

    // A zero duration still plays for one cycle so the requester always gets done.
    assign sel_dur_eff = (sel_dur == '0) ? DUR_W'(1) : sel_dur;

    // The winner is the lowest requesting index, so comparing it against the
    // owner is enough to detect any higher-priority request.
    assign pre_vld = (PREEMPT != 0) && (state_q == ST_PLAY) && sel_vld && (sel_idx < owner_q);

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        dur_d     = dur_q;
        dur_cnt_d = dur_cnt_q;
        gap_cnt_d = gap_cnt_q;
        ack_d     = '0;
        done_d    = '0;
        abort_d   = '0;
        grant     = 1'b0;
        tone_en   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (sel_vld) begin
                    grant = 1'b1;
                end
            end
            ST_PLAY: begin
                // Preemption beats normal completion in the same cycle.
                if (pre_vld) begin
                    abort_d[owner_q] = 1'b1;
                    grant            = 1'b1;
                end else if (dur_cnt_q == dur_q - DUR_W'(1)) begin
                    done_d[owner_q] = 1'b1;
                    if (GAP_CYCLES > 0) begin
                        state_d   = ST_GAP;
                        gap_cnt_d = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    dur_cnt_d = dur_cnt_q + DUR_W'(1);
                    tone_en   = 1'b1;
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (grant) begin
            ack_d[sel_idx] = 1'b1;
            owner_d        = sel_idx;
            dur_d          = sel_dur_eff;
            dur_cnt_d      = '0;
            state_d        = ST_PLAY;
        end

        busy_d  = (state_d != ST_IDLE);
        stale_d = (stale_q & req) | ack_d;
    end

    assign tone_load = grant;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            owner_q   <= '0;
            dur_q     <= '0;
            dur_cnt_q <= '0;
            gap_cnt_q <= '0;
            ack_q     <= '0;
            done_q    <= '0;
            abort_q   <= '0;
            busy_q    <= 1'b0;
            stale_q   <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            dur_q     <= dur_d;
            dur_cnt_q <= dur_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            ack_q     <= ack_d;
            done_q    <= done_d;
            abort_q   <= abort_d;
            busy_q    <= busy_d;
            stale_q   <= stale_d;
        end
    end

    buzzer_tone_gen #(
        .HP_W (HP_W)
    ) u_tone_gen (
        .clk         (clk),
        .rst         (rst),
        .en          (tone_en),
        .load        (tone_load),
        .half_period (sel_hp),
        .buzz        (buzz)
    );

    assign ack   = ack_q;
    assign done  = done_q;
    assign abort = abort_q;
    assign busy  = busy_q;
    assign owner = owner_q;

endmodule
